tl_memory_model: RTL and testbench

- Single-port-style behavioural word memory backing the TileLink L2 adapter.
- Accepts one-cycle write and read request pulses from the adapter.
- Commits writes with per-byte masking and returns read data one cycle later with a valid pulse.
- Mirrors every committed access on monitoring outputs for testbench scoreboards.

---
 rtl/tl_memory_model.sv | 84 ++++++++
 tb/tb_tl_memory_model.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tl_memory_model.sv
// tl_memory_model: behavioural word memory behind the TileLink L2 adapter.
// Ports: clk/rst_n (async active-low reset); write_valid/addr/data/mask in,
// write_ready out; read_valid/addr in, read_data/read_data_valid out;
// mem_write_* and mem_read_* mirror every committed access for scoreboards.
module tl_memory_model #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_valid,
  input  logic [ADDR_BITS-1:0]    write_addr,
  input  logic [DATA_BYTES*8-1:0] write_data,
  input  logic [DATA_BYTES-1:0]   write_mask,
  output logic                    write_ready,
  input  logic                    read_valid,
  input  logic [ADDR_BITS-1:0]    read_addr,
  output logic [DATA_BYTES*8-1:0] read_data,
  output logic                    read_data_valid,
  output logic                    mem_write_valid,
  output logic [ADDR_BITS-1:0]    mem_write_addr,
  output logic [DATA_BYTES*8-1:0] mem_write_data,
  output logic [DATA_BYTES-1:0]   mem_write_mask,
  output logic                    mem_read_valid,
  output logic [ADDR_BITS-1:0]    mem_read_addr,
  output logic [DATA_BYTES*8-1:0] mem_read_data
);
  localparam int DW  = DATA_BYTES * 8;
  localparam int OFF = $clog2(DATA_BYTES);
  localparam int IW  = $clog2(DEPTH);
  logic [DW-1:0]        mem_q [DEPTH];
  logic [DW-1:0]        word_d;
  logic [IW-1:0]        widx, ridx;
  logic                 wv_q, rv_q;
  logic [ADDR_BITS-1:0] waddr_q, raddr_q;
  logic [DW-1:0]        wdata_q, rdata_q;
  logic [DATA_BYTES-1:0] wmask_q;
  assign widx = write_addr[OFF+IW-1:OFF];
  assign ridx = read_addr[OFF+IW-1:OFF];
  always_comb begin
    word_d = mem_q[widx];
    for (int i = 0; i < DATA_BYTES; i++)
      word_d[8*i +: 8] = write_mask[i] ? write_data[8*i +: 8] : word_d[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (write_valid)
      mem_q[widx] <= word_d;
  // The read samples mem_q before the same-edge write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wv_q    <= 1'b0;
      rv_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      wv_q <= write_valid;
      rv_q <= read_valid;
      if (write_valid) begin
        waddr_q <= write_addr;
        wdata_q <= write_data;
        wmask_q <= write_mask;
      end
      if (read_valid) begin
        raddr_q <= read_addr;
        rdata_q <= mem_q[ridx];
      end
    end
  assign write_ready     = wv_q;
  assign mem_write_valid = wv_q;
  assign mem_write_addr  = waddr_q;
  assign mem_write_data  = wdata_q;
  assign mem_write_mask  = wmask_q;
  assign read_data_valid = rv_q;
  assign read_data       = rdata_q;
  assign mem_read_valid  = rv_q;
  assign mem_read_addr   = raddr_q;
  assign mem_read_data   = rdata_q;
endmodule

// File: tb/tb_tl_memory_model.sv
// tb_tl_memory_model: directed plus random stimulus against an array reference model.
module tb_tl_memory_model;
  localparam int AB = 32, DB = 8, DEPTH = 256;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          write_valid = 1'b0, read_valid = 1'b0;
  logic [AB-1:0] write_addr = '0, read_addr = '0;
  logic [63:0]   write_data = '0;
  logic [7:0]    write_mask = '0;
  logic          write_ready, read_data_valid, mem_write_valid, mem_read_valid;
  logic [63:0]   read_data, mem_write_data, mem_read_data;
  logic [AB-1:0] mem_write_addr, mem_read_addr;
  logic [7:0]    mem_write_mask;
  int checks = 0, errors = 0;
  logic [63:0]   ref_mem [DEPTH];
  logic [63:0]   last_rd, last_wd;
  logic [AB-1:0] last_ra, last_wa;
  logic [7:0]    last_wm;

  tl_memory_model #(.ADDR_BITS(AB), .DATA_BYTES(DB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
    .write_mask(write_mask), .write_ready(write_ready),
    .read_valid(read_valid), .read_addr(read_addr), .read_data(read_data),
    .read_data_valid(read_data_valid),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [AB-1:0] a);
    return int'((a / DB) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_rd = '0; last_wd = '0; last_ra = '0; last_wa = '0; last_wm = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, 64'(write_ready), 64'd0);
    chk({tag, "_rdv"}, 64'(read_data_valid), 64'd0);
    chk({tag, "_rd"}, read_data, 64'd0);
    chk({tag, "_mwv"}, 64'(mem_write_valid), 64'd0);
    chk({tag, "_mwa"}, 64'(mem_write_addr), 64'd0);
    chk({tag, "_mwd"}, mem_write_data, 64'd0);
    chk({tag, "_mwm"}, 64'(mem_write_mask), 64'd0);
    chk({tag, "_mrv"}, 64'(mem_read_valid), 64'd0);
    chk({tag, "_mra"}, 64'(mem_read_addr), 64'd0);
    chk({tag, "_mrd"}, mem_read_data, 64'd0);
  endtask

  // One clock: present inputs, take the edge, then compare against the model.
  task automatic step(input logic wv, input logic [AB-1:0] wa, input logic [63:0] wd,
                      input logic [7:0] wm, input logic rv, input logic [AB-1:0] ra);
    write_valid = wv; write_addr = wa; write_data = wd; write_mask = wm;
    read_valid = rv; read_addr = ra;
    @(posedge clk);
    #1;
    if (rv) begin
      last_rd = ref_mem[widx(ra)];
      last_ra = ra;
    end
    if (wv) begin
      for (int b = 0; b < DB; b++)
        if (wm[b]) ref_mem[widx(wa)][8*b +: 8] = wd[8*b +: 8];
      last_wa = wa; last_wd = wd; last_wm = wm;
    end
    chk("write_ready", 64'(write_ready), 64'(wv));
    chk("mem_write_valid", 64'(mem_write_valid), 64'(wv));
    chk("read_data_valid", 64'(read_data_valid), 64'(rv));
    chk("mem_read_valid", 64'(mem_read_valid), 64'(rv));
    chk("read_data", read_data, last_rd);
    chk("mem_read_data", mem_read_data, last_rd);
    chk("mem_read_addr", 64'(mem_read_addr), 64'(last_ra));
    chk("mem_write_addr", 64'(mem_write_addr), 64'(last_wa));
    chk("mem_write_data", mem_write_data, last_wd);
    chk("mem_write_mask", 64'(mem_write_mask), 64'(last_wm));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, '0, '0, '0, 1'b1, 32'h40);
    chk("rd40_data", read_data, 64'd0);
    chk("rd40_addr", 64'(mem_read_addr), 64'h40);

    step(1'b1, 32'h100, 64'h1122334455667788, 8'hFF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h100);
    chk("full_write", read_data, 64'h1122334455667788);

    step(1'b1, 32'h100, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h100);
    chk("partial_write", read_data, 64'h11223344AAAAAAAA);

    step(1'b1, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 1'b0, '0);
    step(1'b1, 32'h808, 64'hFEDCBA9876543210, 8'hFF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h8);
    chk("alias", read_data, 64'hFEDCBA9876543210);
    step(1'b0, '0, '0, '0, 1'b1, 32'hC);
    chk("low_bits", read_data, 64'hFEDCBA9876543210);

    step(1'b1, 32'h200, 64'hDEAD, 8'hFF, 1'b1, 32'h200);
    chk("rbw_old", read_data, 64'd0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h200);
    chk("rbw_new", read_data, 64'hDEAD);

    step(1'b1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h100);
    chk("mask0", read_data, 64'h11223344AAAAAAAA);

    for (int i = 0; i < 400; i++)
      step(1'($urandom), $urandom & 32'h0000_1E3F, {$urandom, $urandom}, 8'($urandom),
           1'($urandom), $urandom & 32'h0000_1E3F);

    write_valid = 1'b1; write_addr = 32'h300; write_data = 64'h5555; write_mask = 8'hFF;
    read_valid = 1'b1; read_addr = 32'h8;
    @(posedge clk);
    #1;
    chk("pre_rst_ready", 64'(write_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    write_valid = 1'b0; read_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, '0, '0, '0, 1'b1, 32'h300);
    chk("post_rst_300", read_data, 64'd0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h100);
    chk("post_rst_100", read_data, 64'd0);
    step(1'b1, 32'h48, 64'hCAFEF00D12345678, 8'hFF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h48);
    repeat (5) begin
      idle();
      chk("hold", read_data, 64'hCAFEF00D12345678);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
